// File: rtl/mlp_stream_bridge.sv
// Host-side bridge for cordic_mlp: packs streamed input features, starts an inference,
// waits (with timeout) for the result, then streams the result words plus argmax class out.
module mlp_stream_bridge #(
    parameter int unsigned INPUT_WIDTH    = 20,
    parameter int unsigned OUTPUT_WIDTH   = 20,
    parameter int unsigned NUM_INPUTS     = 4,
    parameter int unsigned NUM_OUTPUTS    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [INPUT_WIDTH-1:0]                s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic                                  mlp_start,
    output logic [INPUT_WIDTH*NUM_INPUTS-1:0]     mlp_inputs_flat,
    input  logic [OUTPUT_WIDTH*NUM_OUTPUTS-1:0]   mlp_outputs_flat,
    input  logic                                  mlp_valid,
    output logic [OUTPUT_WIDTH-1:0]               m_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic                                  m_last,
    output logic [$clog2(NUM_OUTPUTS)-1:0]        m_class,
    output logic                                  busy,
    output logic                                  timeout_err
);

    localparam int unsigned ICW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
    localparam int unsigned OCW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int unsigned CW  = $clog2(NUM_OUTPUTS);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);

    localparam logic [ICW-1:0] IN_LAST  = ICW'(NUM_INPUTS - 1);
    localparam logic [OCW-1:0] OUT_LAST = OCW'(NUM_OUTPUTS - 1);
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT,
        START,
        WAIT,
        SEND
    } state_t;

    state_t                                r_state;
    state_t                                w_next;
    logic [ICW-1:0]                        r_in_cnt;
    logic [OCW-1:0]                        r_out_cnt;
    logic [TW-1:0]                         r_timer;
    logic [INPUT_WIDTH*NUM_INPUTS-1:0]     r_inputs;
    logic [OUTPUT_WIDTH*NUM_OUTPUTS-1:0]   r_cap;
    logic [CW-1:0]                         r_class;
    logic                                  r_timeout;
    logic signed [OUTPUT_WIDTH-1:0]        w_best_val;
    logic [CW-1:0]                         w_best_idx;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_best_val = mlp_outputs_flat[0 +: OUTPUT_WIDTH];
        w_best_idx = '0;
        for (int unsigned i = 1; i < NUM_OUTPUTS; i++) begin
            if ($signed(mlp_outputs_flat[i*OUTPUT_WIDTH +: OUTPUT_WIDTH]) > w_best_val) begin
                w_best_val = mlp_outputs_flat[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                w_best_idx = CW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        s_ready   = 1'b0;
        mlp_start = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        m_class   = '0;
        busy      = 1'b1;
        case (r_state)
            COLLECT: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid && r_in_cnt == IN_LAST) begin
                    w_next = START;
                end
            end
            START: begin
                mlp_start = 1'b1;
                w_next    = WAIT;
            end
            WAIT: begin
                if (mlp_valid) begin
                    w_next = SEND;
                end else if (r_timer == T_LAST) begin
                    w_next = COLLECT;
                end
            end
            SEND: begin
                m_valid = 1'b1;
                m_data  = r_cap[r_out_cnt*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                m_last  = (r_out_cnt == OUT_LAST);
                m_class = r_class;
                if (m_ready && r_out_cnt == OUT_LAST) begin
                    w_next = COLLECT;
                end
            end
            default: w_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_timer   <= '0;
            r_inputs  <= '0;
            r_cap     <= '0;
            r_class   <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (s_valid) begin
                        r_inputs[r_in_cnt*INPUT_WIDTH +: INPUT_WIDTH] <= s_data;
                        r_in_cnt <= (r_in_cnt == IN_LAST) ? '0 : r_in_cnt + 1'b1;
                    end
                end
                START: begin
                    r_timer <= '0;
                end
                WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (mlp_valid) begin
                        r_cap   <= mlp_outputs_flat;
                        r_class <= w_best_idx;
                    end else if (r_timer == T_LAST) begin
                        r_timeout <= 1'b1;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        r_out_cnt <= (r_out_cnt == OUT_LAST) ? '0 : r_out_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mlp_inputs_flat = r_inputs;
    assign timeout_err     = r_timeout;

endmodule

// File: tb/tb_mlp_stream_bridge.sv
// Directed self-checking bench for mlp_stream_bridge (TIMEOUT_CYCLES overridden to 16).
module tb_mlp_stream_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mlp_start;
    logic [79:0] mlp_inputs_flat;
    logic [59:0] mlp_outputs_flat;
    logic        mlp_valid;
    logic [19:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [1:0]  m_class;
    logic        busy;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_start = 0;
    int n_mvalid = 0;

    mlp_stream_bridge #(
        .INPUT_WIDTH   (20),
        .OUTPUT_WIDTH  (20),
        .NUM_INPUTS    (4),
        .NUM_OUTPUTS   (3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .mlp_start       (mlp_start),
        .mlp_inputs_flat (mlp_inputs_flat),
        .mlp_outputs_flat(mlp_outputs_flat),
        .mlp_valid       (mlp_valid),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .m_class         (m_class),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mlp_start) n_start++;
        if (m_valid)   n_mvalid++;
    end

    task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the START cycle (one cycle after the last handshake).
    task automatic push4(input logic [19:0] a, input logic [19:0] b,
                         input logic [19:0] c, input logic [19:0] d);
        s_valid = 1'b1;
        s_data = a; tick();
        s_data = b; tick();
        s_data = c; tick();
        s_data = d; tick();
        s_valid = 1'b0;
    endtask

    // Called in START; mlp_valid is raised during WAIT cycle dly, leaving the bench in SEND.
    task automatic reply(input logic [59:0] flat, input int dly);
        mlp_outputs_flat = flat;
        repeat (dly) tick();
        check("wait_no_mvalid", m_valid, 1'b0);
        check("wait_busy", busy, 1'b1);
        mlp_valid = 1'b1;
        tick();
        mlp_valid = 1'b0;
    endtask

    task automatic recv3(input logic [19:0] w0, input logic [19:0] w1,
                         input logic [19:0] w2, input logic [1:0] cls);
        logic [19:0] exp_w [3];
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("send_valid", m_valid, 1'b1);
            check("send_data", m_data, exp_w[k]);
            check("send_last", m_last, (k == 2));
            check("send_class", m_class, cls);
            check("send_sready", s_ready, 1'b0);
            tick();
        end
        check("post_send_mvalid", m_valid, 1'b0);
        check("post_send_sready", s_ready, 1'b1);
        check("post_send_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int sc;
        logic [19:0] exp3 [3];
        logic [79:0] held;

        rst = 1'b1; s_data = '0; s_valid = 1'b0; mlp_outputs_flat = '0;
        mlp_valid = 1'b0; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_sready", s_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_mvalid", m_valid, 1'b0);
        check("rst_start", mlp_start, 1'b0);
        check("rst_terr", timeout_err, 1'b0);
        check("rst_flat", mlp_inputs_flat, 80'h0);
        check("rst_mdata", m_data, 20'h0);

        // 1: pack + start pulse
        sc = n_start;
        push4(20'd1, 20'd2, 20'd3, 20'd4);
        check("t1_start", mlp_start, 1'b1);
        check("t1_sready", s_ready, 1'b0);
        check("t1_flat", mlp_inputs_flat, {20'd4, 20'd3, 20'd2, 20'd1});
        // 2: reply ten cycles after start, tie between words 1 and 2
        reply({20'd7, 20'd7, 20'hFFFFB}, 10);
        check("t1_start_count", n_start - sc, 1);
        recv3(20'hFFFFB, 20'd7, 20'd7, 2'd1);

        // 3: m_ready toggling 1010..., negative word must not win argmax
        push4(20'd10, 20'd20, 20'd30, 20'd40);
        reply({20'd50, 20'hFFFFD, 20'd100}, 2);
        exp3[0] = 20'd100; exp3[1] = 20'hFFFFD; exp3[2] = 20'd50;
        k = 0;
        for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
            m_ready = (cyc % 2 == 0);
            check("t3_valid", m_valid, 1'b1);
            check("t3_data", m_data, exp3[k]);
            check("t3_last", m_last, (k == 2));
            check("t3_class", m_class, 2'd0);
            check("t3_sready", s_ready, 1'b0);
            if (m_ready) k++;
            tick();
        end
        check("t3_word_count", k, 3);
        check("t3_done_mvalid", m_valid, 1'b0);
        check("t3_done_sready", s_ready, 1'b1);
        m_ready = 1'b0;

        // mlp_valid on the final WAIT cycle beats the timeout
        push4(20'd5, 20'd6, 20'd7, 20'd8);
        reply({20'd3, 20'd9, 20'd9}, 16);
        check("race_mvalid", m_valid, 1'b1);
        check("race_terr", timeout_err, 1'b0);
        recv3(20'd9, 20'd9, 20'd3, 2'd0);

        // 4: timeout with no reply
        n_mvalid = 0;
        push4(20'd5, 20'd6, 20'd7, 20'd8);
        repeat (16) tick();
        check("t4_still_wait", busy, 1'b1);
        check("t4_terr_early", timeout_err, 1'b0);
        tick();
        check("t4_terr", timeout_err, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_sready", s_ready, 1'b1);
        check("t4_no_mvalid", n_mvalid, 0);
        push4(20'd1, 20'd2, 20'd3, 20'd4);
        reply({20'hFFFFF, 20'd2, 20'hFFFFE}, 3);
        recv3(20'hFFFFE, 20'd2, 20'hFFFFF, 2'd1);
        check("t4_terr_sticky", timeout_err, 1'b1);

        // 5: reset mid-SEND after word 0, then stray mlp_valid in COLLECT
        push4(20'd1, 20'd2, 20'd3, 20'd4);
        reply({20'd3, 20'd2, 20'd1}, 2);
        m_ready = 1'b1;
        tick();
        rst = 1'b1; m_ready = 1'b0;
        tick();
        rst = 1'b0;
        check("t5_mvalid", m_valid, 1'b0);
        check("t5_sready", s_ready, 1'b1);
        check("t5_busy", busy, 1'b0);
        check("t5_terr_clr", timeout_err, 1'b0);
        check("t5_flat_clr", mlp_inputs_flat, 80'h0);
        n_mvalid = 0;
        mlp_valid = 1'b1;
        tick();
        mlp_valid = 1'b0;
        tick(); tick();
        check("t5_stray_mvalid", n_mvalid, 0);
        check("t5_stray_busy", busy, 1'b0);

        // 6: s_valid held with changing data outside COLLECT
        push4(20'd11, 20'd12, 20'd13, 20'd14);
        held = {20'd14, 20'd13, 20'd12, 20'd11};
        s_valid = 1'b1;
        mlp_outputs_flat = {20'd1, 20'd2, 20'd3};
        for (int i = 0; i < 4; i++) begin
            s_data = 20'hA0000 + 20'(i);
            check("t6_flat_hold_wait", mlp_inputs_flat, held);
            tick();
        end
        mlp_valid = 1'b1;
        tick();
        mlp_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 20'hB0000 + 20'(i);
            check("t6_flat_hold_send", mlp_inputs_flat, held);
            tick();
        end
        check("t6_back_collect", s_ready, 1'b1);
        s_data = 20'h00055;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("t6_slot0", mlp_inputs_flat, {20'd14, 20'd13, 20'd12, 20'h00055});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
